// File: rtl/pinwheel_uart_tl_pkg.sv
// Shared constants and types for the pinwheel UART TileLink-UL responder.
// Holds the TileLink A/D channel structs and opcodes, the UART register offsets,
// the STATUS bit indices, the default address tag and the serializer state encoding.
package pinwheel_uart_tl_pkg;

  // TileLink-UL opcodes
  localparam logic [2:0] TlPutFullData    = 3'd0;
  localparam logic [2:0] TlPutPartialData = 3'd1;
  localparam logic [2:0] TlGet            = 3'd4;
  localparam logic [2:0] TlAccessAck      = 3'd0;
  localparam logic [2:0] TlAccessAckData  = 3'd1;

  // a_address[31:28] value that selects the UART
  localparam logic [3:0] UartAddrTag = 4'hB;

  // STATUS bit positions
  localparam int unsigned StEmptyBit    = 0;
  localparam int unsigned StFullBit     = 1;
  localparam int unsigned StBusyBit     = 2;
  localparam int unsigned StOverflowBit = 3;
  localparam int unsigned StCountLsb    = 8;

  // Register index taken from a_address[3:2]
  typedef enum logic [1:0] {
    RegTxData  = 2'd0,
    RegStatus  = 2'd1,
    RegDivisor = 2'd2,
    RegCtrl    = 2'd3
  } uart_reg_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } ser_state_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic        d_error;
    logic [31:0] d_data;
  } tilelink_d;

endpackage

// File: rtl/pinwheel_uart_tl_uart_tx_serializer.sv
// 8N1 transmit serializer: FSM, baud counter and shift register.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   enable_i       allow new frames to start
//   valid_i        a byte is available (FIFO not empty)
//   byte_i         byte at the FIFO head
//   divisor_i      bit period minus one, sampled at every bit boundary
//   pop_o          byte_i consumed this cycle
//   tx_o           registered serial output, idle high
//   busy_o         a frame is in progress
module uart_tx_serializer
  import pinwheel_uart_tl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  input  logic [15:0] divisor_i,
  output logic        pop_o,
  output logic        tx_o,
  output logic        busy_o
);

  ser_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        start_ok;
  logic        bit_done;

  assign start_ok = enable_i && valid_i;
  assign bit_done = (cnt_q == 16'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (start_ok) begin
          pop_o   = 1'b1;
          shift_d = byte_i;
          cnt_d   = divisor_i;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          cnt_d     = divisor_i;
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = divisor_i;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          // Back-to-back frames skip IDLE entirely
          if (start_ok) begin
            pop_o   = 1'b1;
            shift_d = byte_i;
            cnt_d   = divisor_i;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: rtl/pinwheel_uart_tl.sv
// TileLink-UL responder with a 4-word register bank fronting a UART transmitter.
// Stores to TXDATA fill a TX FIFO that the serializer drains onto tx as 8N1.
// Every selected A-beat gets exactly one D-beat in the following cycle.
// Ports:
//   clock          system clock
//   tick_reset_in  synchronous active-high reset
//   bus_tla        A channel from the core
//   bus_tld        registered D channel to the core
//   tx             serial output, idle high
//   tx_irq         TX-idle interrupt, present only when PINWHEEL_UART_TX_IRQ_EN is defined
module pinwheel_uart_tl
  import pinwheel_uart_tl_pkg::*;
#(
  parameter logic [3:0]  ADDR_TAG    = UartAddrTag,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic      clock,
  input  logic      tick_reset_in,
  input  tilelink_a bus_tla,
  output tilelink_d bus_tld,
  output logic      tx
`ifdef PINWHEEL_UART_TX_IRQ_EN
  ,
  output logic      tx_irq
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic      sel;
  logic      put_sel;
  uart_reg_e reg_idx;

  assign sel     = bus_tla.a_valid && (bus_tla.a_address[31:28] == ADDR_TAG);
  assign reg_idx = uart_reg_e'(bus_tla.a_address[3:2]);
  assign put_sel = sel && (bus_tla.a_opcode == TlPutPartialData);

  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     divisor_q, divisor_d;
  logic            enable_q, enable_d;
  tilelink_d       tld_q, tld_d;
`ifdef PINWHEEL_UART_TX_IRQ_EN
  logic            irq_en_q, irq_en_d;
  logic            tx_irq_q, tx_irq_d;
`endif

  logic        fifo_empty, fifo_full;
  logic        push_req, push_ok, pop;
  logic        ser_busy;
  logic [31:0] rdata;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign push_req   = put_sel && (reg_idx == RegTxData) && bus_tla.a_mask[0];
  // A full FIFO still accepts when the serializer frees a slot this cycle
  assign push_ok    = push_req && (!fifo_full || pop);

  uart_tx_serializer u_ser (
    .clk_i     (clock),
    .rst_i     (tick_reset_in),
    .enable_i  (enable_q),
    .valid_i   (!fifo_empty),
    .byte_i    (fifo_mem_q[rd_ptr_q]),
    .divisor_i (divisor_q),
    .pop_o     (pop),
    .tx_o      (tx),
    .busy_o    (ser_busy)
  );

  // Register read value, pre-write
  always_comb begin
    rdata = '0;
    unique case (reg_idx)
      RegTxData: rdata = '0;
      RegStatus: begin
        rdata[StCountLsb +: 4] = 4'(count_q);
        rdata[StOverflowBit]   = overflow_q;
        rdata[StBusyBit]       = ser_busy;
        rdata[StFullBit]       = fifo_full;
        rdata[StEmptyBit]      = fifo_empty;
      end
      RegDivisor: rdata[15:0] = divisor_q;
      RegCtrl: begin
        rdata[0] = enable_q;
`ifdef PINWHEEL_UART_TX_IRQ_EN
        rdata[1] = irq_en_q;
`endif
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    divisor_d  = divisor_q;
    enable_d   = enable_q;
`ifdef PINWHEEL_UART_TX_IRQ_EN
    irq_en_d   = irq_en_q;
    tx_irq_d   = irq_en_q && fifo_empty && !ser_busy;
`endif

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req && !push_ok) overflow_d = 1'b1;

    if (put_sel) begin
      unique case (reg_idx)
        RegStatus: begin
          if (bus_tla.a_mask[0] && bus_tla.a_data[StOverflowBit]) overflow_d = 1'b0;
        end
        RegDivisor: begin
          if (bus_tla.a_mask[0]) divisor_d[7:0]  = bus_tla.a_data[7:0];
          if (bus_tla.a_mask[1]) divisor_d[15:8] = bus_tla.a_data[15:8];
        end
        RegCtrl: begin
          if (bus_tla.a_mask[0]) begin
            enable_d = bus_tla.a_data[0];
`ifdef PINWHEEL_UART_TX_IRQ_EN
            irq_en_d = bus_tla.a_data[1];
`endif
          end
        end
        default: ;
      endcase
    end

    tld_d = '0;
    if (sel) begin
      tld_d.d_valid  = 1'b1;
      tld_d.d_opcode = (bus_tla.a_opcode == TlGet) ? TlAccessAckData : TlAccessAck;
      tld_d.d_size   = bus_tla.a_size;
      tld_d.d_source = bus_tla.a_source;
      tld_d.d_data   = rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      divisor_q  <= DEFAULT_DIV;
      enable_q   <= 1'b0;
      tld_q      <= '0;
`ifdef PINWHEEL_UART_TX_IRQ_EN
      irq_en_q   <= 1'b0;
      tx_irq_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      divisor_q  <= divisor_d;
      enable_q   <= enable_d;
      tld_q      <= tld_d;
`ifdef PINWHEEL_UART_TX_IRQ_EN
      irq_en_q   <= irq_en_d;
      tx_irq_q   <= tx_irq_d;
`endif
    end
  end

  // Storage needs no reset: count/pointers define which entries are live
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= bus_tla.a_data[7:0];
  end

  assign bus_tld = tld_q;
`ifdef PINWHEEL_UART_TX_IRQ_EN
  assign tx_irq = tx_irq_q;
`endif

  // Address offset bits alias; upper data/mask lanes carry nothing
  logic unused_bits;
  assign unused_bits = ^{bus_tla.a_address[27:4], bus_tla.a_address[1:0],
                         bus_tla.a_mask[3:2], bus_tla.a_data[31:16]};

endmodule

// File: tb/tb_pinwheel_uart_tl.sv
// Bench for pinwheel_uart_tl: directed scenarios plus randomized register traffic
// against a queue-based model, with a bit-sampling UART receiver on tx.
module tb_pinwheel_uart_tl;
  import pinwheel_uart_tl_pkg::*;

  localparam int unsigned Depth = 8;

  logic      clock = 1'b0;
  logic      tick_reset_in;
  tilelink_a tla;
  tilelink_d tld;
  logic      tx;
`ifdef PINWHEEL_UART_TX_IRQ_EN
  logic      tx_irq;
`endif

  always #5 clock = ~clock;

  pinwheel_uart_tl #(
    .ADDR_TAG    (4'hB),
    .FIFO_DEPTH  (Depth),
    .DEFAULT_DIV (16'd867)
  ) dut (
    .clock         (clock),
    .tick_reset_in (tick_reset_in),
    .bus_tla       (tla),
    .bus_tld       (tld),
    .tx            (tx)
`ifdef PINWHEEL_UART_TX_IRQ_EN
    ,
    .tx_irq        (tx_irq)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model of the register bank (used while enable stays 0)
  logic [7:0]  m_q[$];
  logic [15:0] m_div;
  logic        m_en, m_irq_en, m_ovf;

  function automatic logic [31:0] model_read(input logic [1:0] r);
    logic [31:0] v;
    v = '0;
    case (r)
      2'd1: begin
        v[11:8] = 4'(m_q.size());
        v[3]    = m_ovf;
        v[1]    = (m_q.size() == Depth);
        v[0]    = (m_q.size() == 0);
      end
      2'd2: v[15:0] = m_div;
      2'd3: begin v[0] = m_en; v[1] = m_irq_en; end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [1:0] r, input logic [3:0] mask, input logic [31:0] data);
    case (r)
      2'd0: if (mask[0]) begin
        if (m_q.size() < Depth) m_q.push_back(data[7:0]);
        else m_ovf = 1'b1;
      end
      2'd1: if (mask[0] && data[3]) m_ovf = 1'b0;
      2'd2: begin
        if (mask[0]) m_div[7:0]  = data[7:0];
        if (mask[1]) m_div[15:8] = data[15:8];
      end
      default: if (mask[0]) begin
        m_en = data[0];
`ifdef PINWHEEL_UART_TX_IRQ_EN
        m_irq_en = data[1];
`endif
      end
    endcase
  endtask

  tilelink_d   rsp;
  logic [1:0]  last_size;
  logic [3:0]  last_src;

  // One A-beat at a negedge; returns at the next negedge with the D-beat captured
  task automatic bus(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data);
    last_size     = 2'($urandom_range(0, 3));
    last_src      = 4'($urandom_range(0, 15));
    tla.a_valid   = 1'b1;
    tla.a_opcode  = op;
    tla.a_size    = last_size;
    tla.a_source  = last_src;
    tla.a_address = addr;
    tla.a_mask    = mask;
    tla.a_data    = data;
    @(posedge clock);
    @(negedge clock);
    rsp         = tld;
    tla.a_valid = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data);
    logic [31:0] exp_data;
    logic        hit;
    hit      = (addr[31:28] == 4'hB);
    exp_data = model_read(addr[3:2]);
    bus(op, addr, mask, data);
    if (hit) begin
      check("d_valid", 32'(rsp.d_valid), 32'd1);
      check("d_opcode", 32'(rsp.d_opcode), (op == TlGet) ? 32'd1 : 32'd0);
      check("d_data", rsp.d_data, exp_data);
      check("d_echo", {26'd0, rsp.d_size, rsp.d_source}, {26'd0, last_size, last_src});
      check("d_zero", {29'd0, rsp.d_param, rsp.d_sink, rsp.d_error}, 32'd0);
      if (op == TlPutPartialData) model_write(addr[3:2], mask, data);
    end else begin
      check("miss_valid", 32'(rsp.d_valid), 32'd0);
      check("miss_data", rsp.d_data, 32'd0);
    end
  endtask

  // Samples each bit in its middle; bit period is div+1 clocks
  task automatic rx_frame(input int unsigned div, output logic [7:0] b);
    int unsigned waited;
    waited = 0;
    b      = '0;
    while (tx !== 1'b0 && waited < 4000) begin
      @(negedge clock);
      waited++;
    end
    if (tx !== 1'b0) begin
      check("rx_start_timeout", 32'(tx), 32'd0);
      return;
    end
    repeat ((div + 1) / 2) @(negedge clock);
    check("rx_start_bit", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (div + 1) @(negedge clock);
      b[i] = tx;
    end
    repeat (div + 1) @(negedge clock);
    check("rx_stop_bit", 32'(tx), 32'd1);
  endtask

  task automatic do_reset();
    tick_reset_in = 1'b1;
    repeat (2) @(negedge clock);
    tick_reset_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  pat, got_b, rb, bytes3 [8];
    logic [31:0] e;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
    logic [1:0]  r;
    logic [2:0]  op;
    int unsigned div, n;

    tla = '0;
    tick_reset_in = 1'b1;
    @(negedge clock);
    do_reset();

    // 1: reset state and STATUS read
    check("rst_tld_ctl", {17'd0, tld.d_valid, tld.d_opcode, tld.d_param, tld.d_size,
                          tld.d_source, tld.d_sink, tld.d_error}, 32'd0);
    check("rst_tld_data", tld.d_data, 32'd0);
    check("rst_tx", 32'(tx), 32'd1);
`ifdef PINWHEEL_UART_TX_IRQ_EN
    check("rst_irq", 32'(tx_irq), 32'd0);
`endif
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("t1_valid", 32'(rsp.d_valid), 32'd1);
    check("t1_opcode", 32'(rsp.d_opcode), 32'd1);
    check("t1_status", rsp.d_data, 32'h0000_0001);
    check("t1_tx", 32'(tx), 32'd1);

    // 2: 0x55 at divisor 3
    bus(TlPutPartialData, 32'hB000_0008, 4'hF, 32'd3);
    check("t2_ack", 32'(rsp.d_opcode), 32'd0);
    bus(TlPutPartialData, 32'hB000_000C, 4'hF, 32'd1);
    bus(TlPutPartialData, 32'hB000_0000, 4'h1, 32'h55);
    @(posedge clock);
    pat = 8'h55;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (k < 4) e = 32'd0;
      else if (k < 36) e = 32'(pat[(k - 4) / 4]);
      else e = 32'd1;
      check($sformatf("t2_tx_k%0d", k), 32'(tx), e);
    end
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("t2_busy_last", rsp.d_data, 32'h0000_0005);
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("t2_idle", rsp.d_data, 32'h0000_0001);

    // 3: fill with enable=0, overflow, clear
    bus(TlPutPartialData, 32'hB000_000C, 4'hF, 32'd0);
    for (int i = 0; i < 8; i++) begin
      bytes3[i] = 8'($urandom);
      bus(TlPutPartialData, 32'hB000_0000, 4'h1, {24'd0, bytes3[i]});
    end
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("t3_full", rsp.d_data, 32'h0000_0802);
    bus(TlPutPartialData, 32'hB000_0000, 4'h1, 32'hEE);
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("t3_ovf", rsp.d_data, 32'h0000_080A);
    bus(TlPutPartialData, 32'hB000_0004, 4'hF, 32'h8);
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("t3_clr", rsp.d_data, 32'h0000_0802);

    // 4: store lands in the cycle of the first pop
    bus(TlPutPartialData, 32'hB000_000C, 4'hF, 32'd1);
    bus(TlPutPartialData, 32'hB000_0000, 4'h1, 32'hA5);
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("t4_status", rsp.d_data, 32'h0000_0806);

    // 5: reset inside data bit 4 of the first frame
    repeat (19) @(negedge clock);
    rb = bytes3[0];
    check("t5_bit4", 32'(tx), 32'(rb[4]));
    tick_reset_in = 1'b1;
    @(negedge clock);
    check("t5_tx_rst", 32'(tx), 32'd1);
    tick_reset_in = 1'b0;
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("t5_status", rsp.d_data, 32'h0000_0001);
    bus(TlGet, 32'hB000_0008, 4'hF, 32'd0);
    check("t5_div", rsp.d_data, 32'd867);
    bus(TlGet, 32'hB000_000C, 4'hF, 32'd0);
    check("t5_ctrl", rsp.d_data, 32'd0);
    bus(TlPutPartialData, 32'hB000_0008, 4'h3, 32'd3);
    bus(TlPutPartialData, 32'hB000_000C, 4'h1, 32'd1);
    rb = 8'($urandom);
    bus(TlPutPartialData, 32'hB000_0000, 4'h1, {24'd0, rb});
    rx_frame(3, got_b);
    check("t5_frame", 32'(got_b), 32'(rb));

    // 6: foreign tag and aliased offset
    repeat (4) @(negedge clock);
    bus(TlGet, 32'hA000_0000, 4'hF, 32'd0);
    check("t6_valid", 32'(rsp.d_valid), 32'd0);
    check("t6_data", rsp.d_data, 32'd0);
    bus(TlGet, 32'hB123_45F4, 4'hF, 32'd0);
    check("t6_alias", rsp.d_data, 32'h0000_0001);

    // Randomized register traffic with the transmitter disabled
    do_reset();
    m_q.delete();
    m_div = 16'd867; m_en = 1'b0; m_irq_en = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tag = ($urandom_range(0, 9) == 0) ? 4'hA : 4'hB;
      r   = 2'($urandom_range(0, 5) > 3 ? 0 : $urandom_range(0, 3));
      addr = {tag, 24'($urandom), r, 2'($urandom)};
      data = $urandom;
      if (r == 2'd3) data[0] = 1'b0;
      case ($urandom_range(0, 2))
        0:       op = TlGet;
        1:       op = TlPutPartialData;
        default: op = TlPutFullData;
      endcase
      do_op(op, addr, 4'($urandom), data);
    end

    // Drain whatever the model holds through the receiver
    if (m_q.size() == 0) do_op(TlPutPartialData, 32'hB000_0000, 4'h1, 32'h3C);
    div = $urandom_range(1, 5);
    do_op(TlPutPartialData, 32'hB000_0008, 4'h3, 32'(div));
    do_op(TlPutPartialData, 32'hB000_000C, 4'h1, 32'd3);
    n = m_q.size();
    for (int i = 0; i < int'(n); i++) begin
      rx_frame(div, got_b);
      check($sformatf("rx_byte%0d", i), 32'(got_b), 32'(m_q.pop_front()));
    end
    repeat (div + 4) @(negedge clock);
    bus(TlGet, 32'hB000_0004, 4'hF, 32'd0);
    check("drain_status", rsp.d_data, 32'h1 | (32'(m_ovf) << 3));
    check("drain_tx", 32'(tx), 32'd1);
`ifdef PINWHEEL_UART_TX_IRQ_EN
    check("irq_idle", 32'(tx_irq), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
